// File: rtl/wb_streamer_pkg.sv
// rtl/wb_streamer_pkg.sv - shared width derivations for the streamer datapath blocks
package wb_streamer_pkg;

    function automatic int calc_ratio(input int in_dw, input int out_dw);
        return out_dw / in_dw;
    endfunction

    // A lane counter needs at least one bit even for a 2:1 ratio.
    function automatic int calc_lane_cnt_w(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - single-entry valid/ready holding register for data, keep and last
module stream_out_reg #(
    parameter int DW = 32,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_tdata,
    input  logic [KW-1:0] s_tkeep,
    input  logic          s_tlast,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic [DW-1:0] m_tdata,
    output logic [KW-1:0] m_tkeep,
    output logic          m_tlast,
    output logic          m_tvalid,
    input  logic          m_tready
);

    // Accepting while draining gives back-to-back words with no bubble.
    assign s_tready = !m_tvalid || m_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tvalid <= 1'b0;
        end else if (s_tvalid && s_tready) begin
            m_tdata  <= s_tdata;
            m_tkeep  <= s_tkeep;
            m_tlast  <= s_tlast;
            m_tvalid <= 1'b1;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_upsizer.sv
// rtl/stream_upsizer.sv - packs narrow beats little-endian into wide words; macro STREAM_UPSIZER_LAST_FLUSH_EN enables early packet flush
module stream_upsizer
    import wb_streamer_pkg::*;
#(
    parameter int IN_DW  = 8,
    parameter int OUT_DW = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [IN_DW-1:0]                    stream_s_data_i,
    input  logic                                stream_s_valid_i,
    input  logic                                stream_s_last_i,
    output logic                                stream_s_ready_o,
    output logic [OUT_DW-1:0]                   stream_m_data_o,
    output logic [calc_ratio(IN_DW, OUT_DW)-1:0] stream_m_keep_o,
    output logic                                stream_m_last_o,
    output logic                                stream_m_valid_o,
    input  logic                                stream_m_ready_i
);

    localparam int RATIO      = calc_ratio(IN_DW, OUT_DW);
    localparam int LANE_CNT_W = calc_lane_cnt_w(RATIO);
    localparam logic [LANE_CNT_W-1:0] LAST_LANE = LANE_CNT_W'(RATIO - 1);

    logic [LANE_CNT_W-1:0] lane_cnt;
    logic [OUT_DW-1:0]     acc;
    logic [OUT_DW-1:0]     word_data;
    logic [RATIO-1:0]      word_keep;
    logic                  word_last;
    logic                  will_complete;
    logic                  beat_fire;
    logic                  out_s_ready;

`ifdef STREAM_UPSIZER_LAST_FLUSH_EN
    assign will_complete = (lane_cnt == LAST_LANE) || stream_s_last_i;
    assign word_last     = stream_s_last_i;

    // Lanes 0..lane_cnt hold real beats; anything above stays zero in acc.
    always_comb begin
        word_keep = '0;
        for (int k = 0; k < RATIO; k++) begin
            word_keep[k] = (LANE_CNT_W'(k) <= lane_cnt);
        end
    end
`else
    logic unused_last;
    assign unused_last   = stream_s_last_i;
    assign will_complete = (lane_cnt == LAST_LANE);
    assign word_last     = 1'b0;
    assign word_keep     = '1;
`endif

    always_comb begin
        word_data = acc;
        for (int k = 0; k < RATIO; k++) begin
            if (lane_cnt == LANE_CNT_W'(k)) begin
                word_data[k*IN_DW +: IN_DW] = stream_s_data_i;
            end
        end
    end

    // Only a word-completing beat needs room in the output register.
    assign stream_s_ready_o = !rst && (!will_complete || out_s_ready);
    assign beat_fire        = stream_s_valid_i && stream_s_ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt <= '0;
            acc      <= '0;
        end else if (beat_fire) begin
            if (will_complete) begin
                lane_cnt <= '0;
                acc      <= '0;
            end else begin
                lane_cnt <= lane_cnt + LANE_CNT_W'(1);
                acc      <= word_data;
            end
        end
    end

    stream_out_reg #(
        .DW(OUT_DW),
        .KW(RATIO)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (word_data),
        .s_tkeep  (word_keep),
        .s_tlast  (word_last),
        .s_tvalid (beat_fire && will_complete),
        .s_tready (out_s_ready),
        .m_tdata  (stream_m_data_o),
        .m_tkeep  (stream_m_keep_o),
        .m_tlast  (stream_m_last_o),
        .m_tvalid (stream_m_valid_o),
        .m_tready (stream_m_ready_i)
    );

endmodule

// File: doc/stream_upsizer.md
STREAM_UPSIZER -- requirements
Module: stream_upsizer

Interface
REQ-001 SHALL have parameter IN_DW, default 8, input stream data width in bits.
REQ-002 SHALL have parameter OUT_DW, default 32, output stream data width; OUT_DW/IN_DW = RATIO, integer >= 2.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port stream_s_data_i  input  IN_DW  input beat data.
REQ-006 SHALL have port stream_s_valid_i  input  1  input beat valid.
REQ-007 SHALL have port stream_s_last_i  input  1  final beat of a packet.
REQ-008 SHALL have port stream_s_ready_o  output  1  input beat accepted when valid && ready.
REQ-009 SHALL have port stream_m_data_o  output  OUT_DW  packed word, feeds the stream writer's stream_s_data_i.
REQ-010 SHALL have port stream_m_keep_o  output  RATIO  per-lane valid flags.
REQ-011 SHALL have port stream_m_last_o  output  1  word closes a packet.
REQ-012 SHALL have port stream_m_valid_o  output  1  output word valid.
REQ-013 SHALL have port stream_m_ready_i  input  1  downstream accepts word when valid && ready.

Function
REQ-014 SHALL pack little-endian: the first accepted beat of a word goes to lane 0 (bits IN_DW-1:0), the k-th to lane k.
REQ-015 SHALL track the next lane in counter lane_cnt, width clog2(RATIO), wrapping from RATIO-1 to 0.
REQ-016 SHALL transfer accumulator plus keep/last to the output register on the cycle the completing beat is accepted; stream_m_valid_o rises the next cycle (latency 1 from the last beat).
REQ-017 SHALL hold stream_m_data_o/keep/last/valid stable while stream_m_valid_o=1 and stream_m_ready_i=0.
REQ-018 SHALL drive stream_s_ready_o=1 when the beat will not complete a word, or the output register is empty, or stream_m_ready_i=1 (combinational m_ready->s_ready path permitted).
REQ-019 SHALL, on a simultaneous output drain and completing input beat, load the new word with no bubble; sustained throughput = 1 input beat/cycle.
REQ-020 SHALL clear stream_m_valid_o after a drain when no new word is loaded the same cycle.
REQ-021 SHALL never drop or duplicate a beat under any valid/ready pattern; input data/last are sampled only when valid && ready.

Reset
REQ-022 SHALL, on rst assertion, immediately clear lane_cnt, accumulator, and keep bits, and set stream_m_valid_o=0, stream_m_last_o=0, stream_m_keep_o=0, stream_m_data_o=0.
REQ-023 SHALL discard any partially packed word and any unaccepted output word on mid-operation reset; the first post-reset beat lands in lane 0.
REQ-024 SHALL hold stream_s_ready_o=0 while rst=1.

Configuration
REQ-025 SHALL compile packet-flush logic only when macro STREAM_UPSIZER_LAST_FLUSH_EN is defined.
REQ-026 SHALL, with STREAM_UPSIZER_LAST_FLUSH_EN, complete a word early on an accepted beat with stream_s_last_i=1: unfilled lanes zero, keep = filled lanes only, stream_m_last_o=1, lane_cnt reset to 0.
REQ-027 SHALL, without STREAM_UPSIZER_LAST_FLUSH_EN, ignore stream_s_last_i, tie stream_m_last_o=0 and stream_m_keep_o all-ones, and emit only full words.

Structure
REQ-028 SHALL take RATIO and LANE_CNT_W derivation functions from shared package wb_streamer_pkg.
REQ-029 SHALL implement the output holding stage as sub-module stream_out_reg (data+keep+last, valid/ready register).

Verification
REQ-030 SHALL verify: bytes 0x11,0x22,0x33,0x44 back-to-back, m_ready=1 -> one word 0x44332211, keep=0xF, valid 1 cycle after beat 4.
REQ-031 SHALL verify: 8 beats 0x01..0x08 with m_ready held 0 until cycle 10 -> s_ready drops after beat 8 until drain; words 0x04030201 then 0x08070605, none lost.
REQ-032 SHALL verify (flush enabled): 0xAA,0xBB with last on 0xBB -> word 0x0000BBAA, keep=0x3, last=1; next beat lands in lane 0.
REQ-033 SHALL verify (flush disabled): same stimulus plus 0xCC,0xDD -> single word 0xDDCCBBAA, keep=0xF, last=0.
REQ-034 SHALL verify: rst asserted after 3 beats of a word -> outputs 0 within same cycle; post-reset 0x01..0x04 yields 0x04030201.
REQ-035 SHALL verify: 1000 random bytes, random valid and m_ready -> output word stream equals reference packing.
